// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multicycle ARM datapath
`timescale 1ns/1ps

module multicycle_controller (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [3:0] State,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] cmd;
  logic       alu_op;
  logic       branch;
  logic       ir_write_raw;
  logic       next_pc_raw;
  logic       reg_w_raw;
  logic       mem_w_raw;
  logic [1:0] flag_w_raw;

  assign cmd   = Funct[4:1];
  assign State = state_q;

  // State register; reset drops straight back to FETCH without a clock.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next-state sequencing; illegal codes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; anything not named in a state stays 0.
  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    alu_op       = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
      end
      S_EXECR: begin
        alu_op = 1'b1;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: begin
        reg_w_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: begin
        ir_write_raw = 1'b0;
      end
    endcase
  end

  // ALU decode: only the four supported commands produce flag-write intents.
  always_comb begin
    ALUControl = 2'b00;
    flag_w_raw = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: begin
          ALUControl = 2'b00;
          flag_w_raw = {Funct[0], Funct[0]};
        end
        4'b0010: begin
          ALUControl = 2'b01;
          flag_w_raw = {Funct[0], Funct[0]};
        end
        4'b0000: begin
          ALUControl = 2'b10;
          flag_w_raw = {Funct[0], 1'b0};
        end
        4'b1100: begin
          ALUControl = 2'b11;
          flag_w_raw = {Funct[0], 1'b0};
        end
        default: begin
          ALUControl = 2'b00;
          flag_w_raw = 2'b00;
        end
      endcase
    end
  end

  // Enables are masked by reset so FETCH held in reset does not load IR/PC.
  assign IRWrite = ir_write_raw & nRESET;
  assign NextPC  = next_pc_raw & nRESET;
  assign RegW    = reg_w_raw & nRESET;
  assign MemW    = mem_w_raw & nRESET;
  assign FlagW   = flag_w_raw & {2{nRESET}};
  assign PCS     = (branch | (reg_w_raw & (Rd == 4'hF))) & nRESET;

  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == 2'b01), (Op == 2'b10)};

endmodule
